// File: rtl/jtag_vector_engine_if.sv
// Register-side and pin-side signal bundle of the JTAG vector shift engine.
// master = register block / pins driver, slave = jtag_vector_engine.
interface jtag_vector_engine_if #(
  parameter int C_VECTOR_WIDTH = 64,
  parameter int C_DIV_WIDTH    = 8
);
  localparam int LW = $clog2(C_VECTOR_WIDTH) + 1;

  logic                      START;
  logic                      ABORT;
  logic [LW-1:0]             LENGTH;
  logic [C_DIV_WIDTH-1:0]    DIVIDER;
  logic [C_VECTOR_WIDTH-1:0] TMS_VECTOR;
  logic [C_VECTOR_WIDTH-1:0] TDI_VECTOR;
  logic [C_VECTOR_WIDTH-1:0] TDO_VECTOR;
  logic                      BUSY;
  logic                      DONE;
  logic                      TCK;
  logic                      TMS;
  logic                      TDI;
  logic                      TDO;

  modport master (
    output START, ABORT, LENGTH, DIVIDER, TMS_VECTOR, TDI_VECTOR, TDO,
    input  TDO_VECTOR, BUSY, DONE, TCK, TMS, TDI
  );

  modport slave (
    input  START, ABORT, LENGTH, DIVIDER, TMS_VECTOR, TDI_VECTOR, TDO,
    output TDO_VECTOR, BUSY, DONE, TCK, TMS, TDI
  );
endinterface

// File: rtl/jtag_vector_engine.sv
// JTAG shift engine: clocks LENGTH bits of TMS/TDI out LSB first and captures TDO.
// Optional macro JTAG_TDO_SYNC_EN adds a two-flop TDO synchroniser (capture on TCK fall).
module jtag_vector_engine #(
  parameter int C_VECTOR_WIDTH = 64,
  parameter int C_DIV_WIDTH    = 8
) (
  input logic                CLK,
  input logic                RESET,
  jtag_vector_engine_if.slave bus
);

  localparam int LW = $clog2(C_VECTOR_WIDTH) + 1;
  localparam int IW = $clog2(C_VECTOR_WIDTH);
  localparam logic [LW-1:0] WMAX = LW'(C_VECTOR_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [C_DIV_WIDTH-1:0]    cnt_q;
  logic [C_DIV_WIDTH-1:0]    div_q;
  logic [IW-1:0]             idx_q;
  logic [IW-1:0]             idx_nxt;
  logic [LW-1:0]             len_q;
  logic [LW-1:0]             len_m1;
  logic [C_VECTOR_WIDTH-1:0] tms_vec_q;
  logic [C_VECTOR_WIDTH-1:0] tdi_vec_q;
  logic [C_VECTOR_WIDTH-1:0] tdo_vec_q;
  logic                      tck_q, tms_q, tdi_q;
  logic                      busy_q, done_q;
  logic                      last_bit;
  logic                      accept, zero_start, rise, fall, abort_now;

  // Requests longer than the vector saturate to the full width.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l > WMAX) return WMAX;
    return l;
  endfunction

  function automatic logic [C_DIV_WIDTH-1:0] eff_div(input logic [C_DIV_WIDTH-1:0] d);
`ifdef JTAG_TDO_SYNC_EN
    // The synchroniser needs at least three CLK cycles per TCK half-period.
    if (d < C_DIV_WIDTH'(2)) return C_DIV_WIDTH'(2);
    return d;
`else
    return d;
`endif
  endfunction

  assign len_m1   = len_q - LW'(1);
  assign last_bit = ({1'b0, idx_q} == len_m1);
  assign idx_nxt  = idx_q + IW'(1);

`ifdef JTAG_TDO_SYNC_EN
  logic tdo_s1_q, tdo_s2_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tdo_s1_q <= 1'b0;
      tdo_s2_q <= 1'b0;
    end else begin
      tdo_s1_q <= bus.TDO;
      tdo_s2_q <= tdo_s1_q;
    end
  end
`else
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    zero_start = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    abort_now  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.LENGTH != '0) begin
            accept  = 1'b1;
            state_d = LOW;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      LOW: begin
        if (bus.ABORT) begin
          abort_now = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == '0) begin
          rise    = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (bus.ABORT) begin
          abort_now = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == '0) begin
          fall    = 1'b1;
          state_d = last_bit ? IDLE : LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Half-period counter: reloaded on every state entry, counts down to zero.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= eff_div(bus.DIVIDER);
    end else if (rise || fall) begin
      cnt_q <= div_q;
    end else if (abort_now) begin
      cnt_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - C_DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      tms_vec_q <= '0;
      tdi_vec_q <= '0;
      tdo_vec_q <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b0;
      tdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        div_q     <= eff_div(bus.DIVIDER);
        len_q     <= clamp_len(bus.LENGTH);
        idx_q     <= '0;
        tms_vec_q <= bus.TMS_VECTOR;
        tdi_vec_q <= bus.TDI_VECTOR;
        tdo_vec_q <= '0;
        tck_q     <= 1'b0;
        tms_q     <= bus.TMS_VECTOR[0];
        tdi_q     <= bus.TDI_VECTOR[0];
        busy_q    <= 1'b1;
      end else if (zero_start) begin
        tdo_vec_q <= '0;
        done_q    <= 1'b1;
      end else if (abort_now) begin
        // TMS is left alone so the TAP stays in whatever state it reached.
        tck_q  <= 1'b0;
        tdi_q  <= 1'b0;
        busy_q <= 1'b0;
      end else if (rise) begin
        tck_q <= 1'b1;
`ifdef JTAG_TDO_SYNC_EN
`else
        tdo_vec_q[idx_q] <= bus.TDO;
`endif
      end else if (fall) begin
        tck_q <= 1'b0;
`ifdef JTAG_TDO_SYNC_EN
        tdo_vec_q[idx_q] <= tdo_s2_q;
`else
`endif
        if (last_bit) begin
          tdi_q  <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q <= idx_nxt;
          tms_q <= tms_vec_q[idx_nxt];
          tdi_q <= tdi_vec_q[idx_nxt];
        end
      end
    end
  end

  assign bus.TDO_VECTOR = tdo_vec_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.TCK        = tck_q;
  assign bus.TMS        = tms_q;
  assign bus.TDI        = tdi_q;

endmodule

// File: tb/tb_jtag_vector_engine.sv
// Directed bench for jtag_vector_engine: expected TDO vectors go through a queue
// and are compared when DONE (or an abort) completes a shift.
module tb_jtag_vector_engine;
  localparam int W  = 64;
  localparam int DW = 8;
  localparam int LW = $clog2(W) + 1;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  jtag_vector_engine_if #(.C_VECTOR_WIDTH(W), .C_DIV_WIDTH(DW)) bus ();

  jtag_vector_engine #(.C_VECTOR_WIDTH(W), .C_DIV_WIDTH(DW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  logic         loop_mode = 1'b0;
  logic [W-1:0] pat = '0;
  int           rise_cnt = 0;
  int           base = 0;
  logic         tck_prev = 1'b0;
  logic [31:0]  rel;

  assign rel     = 32'(rise_cnt - base);
  assign bus.TDO = loop_mode ? bus.TDI : pat[rel[5:0]];

  always @(negedge CLK) begin
    tck_prev <= bus.TCK;
    if (bus.TCK && !tck_prev) rise_cnt <= rise_cnt + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.TDO_VECTOR, e);
    end
  endtask

  task automatic start(input int n, input int d, input logic [W-1:0] tms,
                       input logic [W-1:0] tdi, input logic lp, input logic [W-1:0] p);
    @(negedge CLK);
    loop_mode      = lp;
    pat            = p;
    base           = rise_cnt;
    bus.LENGTH     = LW'(n);
    bus.DIVIDER    = DW'(d);
    bus.TMS_VECTOR = tms;
    bus.TDI_VECTOR = tdi;
    bus.START      = 1'b1;
    @(posedge CLK);
  endtask

  // Counts CLK edges after the accept edge until DONE is seen.
  task automatic wait_done(input logic hold, input int limit, output int e,
                           output int first, output logic b0);
    e = 0;
    first = -1;
    b0 = 1'b0;
    forever begin
      @(negedge CLK);
      bus.START = hold;
      if (e == 0) b0 = bus.BUSY;
      if (bus.TCK && first < 0) first = e;
      if (bus.DONE) break;
      if (e >= limit) begin
        total++;
        bad++;
        $error("FAIL done_timeout observed=%0d expected<%0d", e, limit);
        break;
      end
      @(posedge CLK);
      e++;
    end
  endtask

  initial begin
    int e, first, dn;
    logic b0;
    logic [W-1:0] rv;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.LENGTH = '0;
    bus.DIVIDER = '0;
    bus.TMS_VECTOR = '0;
    bus.TDI_VECTOR = '0;

    repeat (3) @(negedge CLK);
    check("rst_tck", W'(bus.TCK), 0);
    check("rst_tms", W'(bus.TMS), 0);
    check("rst_tdi", W'(bus.TDI), 0);
    check("rst_busy", W'(bus.BUSY), 0);
    check("rst_done", W'(bus.DONE), 0);
    check("rst_tdovec", bus.TDO_VECTOR, 0);
    RESET = 1'b0;

    // Reset asserted in the middle of a 16-bit shift
    start(16, 3, '1, '1, 1'b1, '0);
    @(negedge CLK);
    bus.START = 1'b0;
    repeat (19) @(negedge CLK);
    check("pre_rst_busy", W'(bus.BUSY), 1);
    #2 RESET = 1'b1;
    #1;
    check("midrst_tck", W'(bus.TCK), 0);
    check("midrst_tms", W'(bus.TMS), 0);
    check("midrst_tdi", W'(bus.TDI), 0);
    check("midrst_busy", W'(bus.BUSY), 0);
    check("midrst_done", W'(bus.DONE), 0);
    check("midrst_tdovec", bus.TDO_VECTOR, 0);
    @(negedge CLK);
    RESET = 1'b0;

    // N=8, D=0, loopback
    exp_q.push_back(64'hA5);
    start(8, 0, 64'h1F, 64'hA5, 1'b1, '0);
    wait_done(1'b0, 1000, e, first, b0);
    check("n8_busy", W'(b0), 1);
    check("n8_done_edge", W'(e), 16);
    check("n8_first_rise", W'(first), 1);
    check("n8_rises", W'(rel), 8);
    pop_check("n8_tdovec");
    @(negedge CLK);
    check("n8_done_once", W'(bus.DONE), 0);
    check("n8_tms_hold", W'(bus.TMS), 0);
    check("n8_tdi_idle", W'(bus.TDI), 0);
    check("n8_busy_off", W'(bus.BUSY), 0);

    // Full width, D=4, TDO from pattern
    exp_q.push_back(64'hDEADBEEF_01234567);
    start(64, 4, '0, '0, 1'b0, 64'hDEADBEEF_01234567);
    wait_done(1'b0, 2000, e, first, b0);
    check("n64_done_edge", W'(e), 640);
    check("n64_first_rise", W'(first), 5);
    check("n64_rises", W'(rel), 64);
    pop_check("n64_tdovec");

    // Zero length
    exp_q.push_back('0);
    start(0, 2, '1, '1, 1'b1, '0);
    wait_done(1'b0, 50, e, first, b0);
    check("n0_done_edge", W'(e), 0);
    check("n0_busy", W'(b0), 0);
    check("n0_no_tck", W'(first), 64'hFFFF_FFFF_FFFF_FFFF);
    pop_check("n0_tdovec");
    @(negedge CLK);
    check("n0_done_once", W'(bus.DONE), 0);
    check("n0_rises", W'(rel), 0);

    // Length 100 saturates to 64
    rv = {$urandom, $urandom};
    exp_q.push_back(rv);
    start(100, 0, '0, rv, 1'b1, '0);
    wait_done(1'b0, 1000, e, first, b0);
    check("n100_done_edge", W'(e), 128);
    check("n100_rises", W'(rel), 64);
    pop_check("n100_tdovec");

    // Abort after three TCK rises, START during BUSY ignored
    exp_q.push_back(64'h7);
    start(10, 1, '0, 64'h3FF, 1'b1, '0);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #1;
      bus.START = (rel == 1);
      bus.LENGTH = LW'(2);
      if (rel >= 3) break;
    end
    check("abt_rises", W'(rel), 3);
    bus.START = 1'b0;
    bus.ABORT = 1'b1;
    @(posedge CLK);
    #1;
    check("abt_tck", W'(bus.TCK), 0);
    check("abt_busy", W'(bus.BUSY), 0);
    check("abt_tdi", W'(bus.TDI), 0);
    @(negedge CLK);
    bus.ABORT = 1'b0;
    dn = 0;
    repeat (30) begin
      @(negedge CLK);
      if (bus.DONE) dn++;
    end
    check("abt_no_done", W'(dn), 0);
    check("abt_rises_after", W'(rel), 3);
    pop_check("abt_tdovec");

    // Back-to-back with START held through DONE
    exp_q.push_back(64'h5);
    exp_q.push_back(64'h5);
    start(4, 0, '0, 64'h5, 1'b1, '0);
    wait_done(1'b1, 200, e, first, b0);
    check("b2b_done1_edge", W'(e), 8);
    pop_check("b2b_tdovec1");
    @(posedge CLK);
    #1;
    check("b2b_no_gap", W'(bus.BUSY), 1);
    check("b2b_done1_once", W'(bus.DONE), 0);
    base = rise_cnt;
    wait_done(1'b0, 200, e, first, b0);
    check("b2b_done2_edge", W'(e), 8);
    check("b2b_rises2", W'(rel), 4);
    pop_check("b2b_tdovec2");
    @(negedge CLK);
    check("b2b_done2_once", W'(bus.DONE), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
